// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: FSM state encoding and sizing helpers shared by the sequential ripple adder
package seq_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: CHUNK-bit combinational ripple of full adders; ports a, b, cin -> sum, cout, c_msb_in (carry into top bit)
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic c;
  always_comb begin
    sum = '0;
    c = cin;
    c_msb_in = cin;
    for (int i = 0; i < CHUNK; i++) begin
      c_msb_in = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/seq_ripple_adder.sv
// seq_ripple_adder: multi-cycle CHUNK-per-cycle add/sub with valid/ready; ports in_valid/in_ready/x/y/ci/sub -> out_valid/out_ready/s/co/ovf
module seq_ripple_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW = idx_w(NCHUNK);
  localparam logic [IW-1:0] K_LAST = IW'(NCHUNK - 1);
  state_t state;
  logic [IW-1:0] k;
  logic carry;
  logic [WIDTH-1:0] xr, yr;
  logic [CHUNK-1:0] sum;
  logic cout, c_msb_in;
  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a(xr[k*CHUNK +: CHUNK]),
    .b(yr[k*CHUNK +: CHUNK]),
    .cin(carry),
    .sum(sum),
    .cout(cout),
    .c_msb_in(c_msb_in)
  );
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // Subtraction is x + ~y + ~borrow, so invert y and the incoming borrow at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      carry <= 1'b0;
      xr <= '0;
      yr <= '0;
      s <= '0;
      co <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xr <= x;
          yr <= y ^ {WIDTH{sub}};
          carry <= ci ^ sub;
          k <= '0;
          state <= RUN;
        end
        RUN: begin
          s[k*CHUNK +: CHUNK] <= sum;
          carry <= cout;
          if (k == K_LAST) begin
            co <= cout;
            ovf <= c_msb_in ^ cout;
            state <= DONE;
          end else k <= k + IW'(1);
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_ripple_adder.sv
// tb_seq_ripple_adder: table-driven and scoreboarded checks of seq_ripple_adder at 8/2 and 2/1 geometries
module tb_seq_ripple_adder;
  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       ci;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid8 = 1'b0, in_ready8, ci8 = 1'b0, sub8 = 1'b0, out_valid8, out_ready8 = 1'b1, co8, ovf8;
  logic [7:0] x8 = '0, y8 = '0, s8;
  logic in_valid2 = 1'b0, in_ready2, ci2 = 1'b0, sub2 = 1'b0, out_valid2, out_ready2 = 1'b1, co2, ovf2;
  logic [1:0] x2 = '0, y2 = '0, s2;
  int checks = 0;
  int errors = 0;
  vec_t q8[$];
  vec_t q2[$];
  vec_t tbl8[9];
  vec_t tbl2[5];
  always #5 clk = ~clk;
  seq_ripple_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .ci(ci8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .s(s8), .co(co8), .ovf(ovf8)
  );
  seq_ripple_adder #(.WIDTH(2), .CHUNK(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .x(x2), .y(y2), .ci(ci2), .sub(sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .s(s2), .co(co2), .ovf(ovf2)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  function automatic vec_t model8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sb);
    vec_t v;
    logic [8:0] f;
    logic [7:0] bb;
    bb = sb ? ~b : b;
    f = {1'b0, a} + {1'b0, bb} + 9'(c ^ sb);
    v.x = a; v.y = b; v.ci = c; v.sub = sb;
    v.s = f[7:0];
    v.co = f[8];
    v.ovf = (a[7] == bb[7]) && (f[7] != a[7]);
    return v;
  endfunction
  task automatic run8(input vec_t v, input int hold);
    vec_t e;
    int n;
    logic [7:0] hs;
    logic hco, hovf;
    @(negedge clk);
    x8 = v.x; y8 = v.y; ci8 = v.ci; sub8 = v.sub;
    in_valid8 = 1'b1;
    out_ready8 = hold == 0;
    #1 chk("in_ready_idle8", in_ready8, 1);
    q8.push_back(v);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    x8 = 8'($urandom); y8 = 8'($urandom); ci8 = 1'($urandom); sub8 = 1'($urandom);
    chk("in_ready_run8", in_ready8, 0);
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency8", n, 4);
    chk("out_valid8", out_valid8, 1);
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk("s8", s8, e.s);
      chk("co8", co8, e.co);
      chk("ovf8", ovf8, e.ovf);
    end
    hs = s8; hco = co8; hovf = ovf8;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid8, 1);
      chk("bp_ready", in_ready8, 0);
      chk("bp_s", s8, hs);
      chk("bp_co_ovf", {co8, ovf8}, {hco, hovf});
    end
    if (hold > 0) begin
      @(negedge clk);
      out_ready8 = 1'b1;
    end
    @(posedge clk); #1;
    chk("idle_after8", in_ready8, 1);
    chk("valid_drop8", out_valid8, 0);
  endtask
  task automatic run2(input vec_t v);
    vec_t e;
    int n;
    @(negedge clk);
    x2 = v.x[1:0]; y2 = v.y[1:0]; ci2 = v.ci; sub2 = v.sub;
    in_valid2 = 1'b1;
    q2.push_back(v);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    x2 = 2'($urandom); y2 = 2'($urandom);
    n = 0;
    while (!out_valid2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency2", n, 2);
    if (q2.size() > 0) begin
      e = q2.pop_front();
      chk("s2", s2, e.s);
      chk("co2", co2, e.co);
      chk("ovf2", ovf2, e.ovf);
    end
    @(posedge clk); #1;
    chk("idle_after2", in_ready2, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic seen;
    tbl8[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl8[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl8[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl8[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl8[4] = '{8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
    tbl8[5] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl8[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl8[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl8[8] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl2[0] = '{8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl2[1] = '{8'd1, 8'd0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0};
    tbl2[2] = '{8'd2, 8'd1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0};
    tbl2[3] = '{8'd2, 8'd3, 1'b0, 1'b0, 8'd1, 1'b1, 1'b1};
    tbl2[4] = '{8'd3, 8'd3, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0};
    #12;
    chk("rst_in_ready", in_ready8, 1);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_s_co_ovf", {s8, co8, ovf8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) run8(tbl8[i], 0);
    for (int i = 0; i < 5; i++) run2(tbl2[i]);
    for (int i = 0; i < 8; i++)
      run8(model8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom)), 0);
    run8(model8(8'h12, 8'h34, 1'b0, 1'b0), 10);
    @(negedge clk);
    x8 = 8'h3C; y8 = 8'h5A; ci8 = 1'b0; sub8 = 1'b0;
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid8, 0);
    chk("abort_in_ready", in_ready8, 1);
    chk("abort_s_co_ovf", {s8, co8, ovf8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid8) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    run8(model8(8'h3C, 8'h5A, 1'b1, 1'b0), 0);
    chk("queue_empty", q8.size() + q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_ripple_adder.md
# seq_ripple_adder

Parametrised multi-cycle ripple-carry adder/subtractor, the successor to our fixed 2-bit combinational ripple adder. It processes a WIDTH-bit operand pair CHUNK bits per cycle, LSB chunk first, with the carry held in a register between chunks. It has valid/ready handshakes on input and output, borrow-style subtraction, carry-in, and signed-overflow reporting. It sits between operand-producing logic and a result consumer where a full-width single-cycle carry chain would not meet timing.

## Interface
- WIDTH, 8, operand/result width; must be a multiple of CHUNK
- CHUNK, 2, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept; high only in IDLE
- x  in  WIDTH  operand X
- y  in  WIDTH  operand Y
- ci  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: x+y+ci; 1: x−y−ci
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- s  out  WIDTH  sum/difference
- co  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  two's-complement overflow

## Operation
- NCHUNK = WIDTH/CHUNK. States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready: capture x, y ^ {WIDTH{sub}}, carry ← ci ^ sub, chunk index k ← 0, go to RUN.
- RUN: each cycle add chunk k of captured x, captured y and the carry register; write the CHUNK sum bits into s[k*CHUNK +: CHUNK] and update carry. On k = NCHUNK−1, latch co = final carry, ovf = (carry into MSB) ^ (carry out of MSB), then go to DONE; otherwise k ← k+1.
- DONE: out_valid=1. s, co, ovf are held stable. On out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. No new operand is accepted until the result has been taken.
- Input x, y, ci, sub are ignored outside the accept cycle. Changing them mid-RUN has no effect.
- All arithmetic is modulo 2^WIDTH. CHUNK = WIDTH gives a single RUN cycle.
- s is undefined-but-deterministic during RUN. Only out_valid qualifies s, co and ovf.

## Timing
- Reset (async assert, sync deassert handled upstream): state=IDLE, k=0, carry=0, s=0, co=0, ovf=0, out_valid=0, in_ready=1.
- Reset mid-RUN or mid-DONE aborts the operation. No out_valid is produced and no result is retained.
- Latency: accept at edge E; out_valid is high after edge E+NCHUNK.
- Minimum period per operation is NCHUNK+2 cycles: accept, NCHUNK RUN cycles, one DONE cycle with out_ready=1.
- out_ready held low keeps the block in DONE indefinitely with outputs stable.
- in_valid during RUN/DONE is not accepted. The producer must hold it, per standard valid/ready rules.

## Structure
- Package seq_adder_pkg: state enum (IDLE, RUN, DONE) and a localparam helper for NCHUNK and index width ($clog2(NCHUNK), minimum 1).
- Sub-module chunk_adder: combinational CHUNK-bit ripple of full adders. Inputs a, b, cin; outputs sum, cout, and c_msb_in (the carry into the top bit, used for ovf). One instance is shared across all chunks via muxing on k.
- Top level holds the FSM, operand registers, carry register, chunk counter and result registers.

## Test plan
- WIDTH=8, CHUNK=2, add 0x00+0x00, ci=0 -> after 4 cycles out_valid=1, s=0x00, co=0, ovf=0.
- Add 0xFF+0x01, ci=0 -> s=0x00, co=1, ovf=0. Add 0x7F+0x01 -> s=0x80, co=0, ovf=1.
- sub=1: 0x05−0x07, ci=0 -> s=0xFE, co=0, ovf=0. 0x80−0x01 -> s=0x7F, co=1, ovf=1. 0x05−0x02, ci=1 -> s=0x02, co=1.
- Backpressure: out_ready=0 for 10 cycles -> out_valid, s, co, ovf stable and in_ready=0 throughout. Then out_ready=1 -> IDLE next cycle and in_ready=1.
- Reset asserted at RUN cycle 2 -> all outputs immediately at reset values, and no out_valid follows. A new op after release completes correctly.
- WIDTH=2, CHUNK=1 regression vectors (x,y): (0,0)->s=0,co=0; (1,0)->1,0; (2,1)->3,0; (2,3)->1,1; (3,3)->2,1. Each completes in 2 cycles.
